ssd_capture: RTL

- Monitors a multiplexed, active-low 4-digit seven-segment display bus (segment lines plus digit enables) and reconstructs the displayed hex value.
- This is the reverse of the team's hex-to-segment decoders: it turns segment patterns back into nibbles.
- Used as an on-board display self-check: a display driver's output loops back into this block, and the recovered value is compared or logged.
- Each digit is committed only after its pattern has been stable for a programmable number of cycles.

---
 rtl/ssd_capture.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ssd_capture.sv
// ssd_capture: watches an active-low multiplexed 4-digit seven-segment bus
// and recovers the hex value shown. A digit is committed only after its
// pattern and digit enable have been steady for STABLE_CYCLES cycles.
module ssd_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic [3:0]  bad_pattern,
  output logic        commit,
  output logic        frame_done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_PRE = 8'(STABLE_CYCLES - 1);

  // Returns {legal, blank, nibble} for an active-low gfedcba pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] pat_n);
    logic [5:0] res;
    res = 6'h00;
    case (~pat_n)
      7'h3F:   res = {2'b10, 4'h0};
      7'h06:   res = {2'b10, 4'h1};
      7'h5B:   res = {2'b10, 4'h2};
      7'h4F:   res = {2'b10, 4'h3};
      7'h66:   res = {2'b10, 4'h4};
      7'h6D:   res = {2'b10, 4'h5};
      7'h7D:   res = {2'b10, 4'h6};
      7'h07:   res = {2'b10, 4'h7};
      7'h7F:   res = {2'b10, 4'h8};
      7'h6F:   res = {2'b10, 4'h9};
      7'h77:   res = {2'b10, 4'hA};
      7'h7C:   res = {2'b10, 4'hB};
      7'h39:   res = {2'b10, 4'hC};
      7'h5E:   res = {2'b10, 4'hD};
      7'h79:   res = {2'b10, 4'hE};
      7'h71:   res = {2'b10, 4'hF};
      7'h00:   res = {2'b01, 4'h0};
      default: res = {2'b00, 4'h0};
    endcase
    return res;
  endfunction

  logic [6:0] seg_q_r;
  logic [3:0] an_q_r;
  logic       sel_ok_s;
  logic [1:0] idx_s;

  state_t     state_r, state_nxt_s;
  logic [7:0] cnt_r, cnt_nxt_s;
  logic [1:0] cur_idx_r, cur_idx_nxt_s;
  logic [6:0] cur_pat_r, cur_pat_nxt_s;
  logic       commit_nxt_s;

  logic [3:0]  seen_r, seen_nxt_s, seen_or_s;
  logic [15:0] value_nxt_s;
  logic [3:0]  valid_nxt_s, bad_nxt_s;
  logic        frame_nxt_s;
  logic [5:0]  dec_s;

  // Input stage: register the raw bus every cycle; reset loads the idle levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q_r <= 7'h7F;
      an_q_r  <= 4'hF;
    end else begin
      seg_q_r <= seg_n;
      an_q_r  <= an_n;
    end
  end

  // Digit selection: valid only when exactly one enable is active.
  always_comb begin
    sel_ok_s = 1'b0;
    idx_s    = 2'd0;
    case (an_q_r)
      4'b1110: begin sel_ok_s = 1'b1; idx_s = 2'd0; end
      4'b1101: begin sel_ok_s = 1'b1; idx_s = 2'd1; end
      4'b1011: begin sel_ok_s = 1'b1; idx_s = 2'd2; end
      4'b0111: begin sel_ok_s = 1'b1; idx_s = 2'd3; end
      default: begin sel_ok_s = 1'b0; idx_s = 2'd0; end
    endcase
  end

  // Tracker state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      cur_idx_r <= 2'd0;
      cur_pat_r <= 7'h7F;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      cur_idx_r <= cur_idx_nxt_s;
      cur_pat_r <= cur_pat_nxt_s;
    end
  end

  // Tracker next state: restart on any change, commit once when the count reaches the threshold.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    cur_idx_nxt_s = cur_idx_r;
    cur_pat_nxt_s = cur_pat_r;
    commit_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel_ok_s) begin
          state_nxt_s   = TRACK;
          cur_idx_nxt_s = idx_s;
          cur_pat_nxt_s = seg_q_r;
          cnt_nxt_s     = 8'd1;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 8'd0;
        end
      end
      TRACK: begin
        if (!sel_ok_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 8'd0;
        end else if ((idx_s != cur_idx_r) || (seg_q_r != cur_pat_r)) begin
          cur_idx_nxt_s = idx_s;
          cur_pat_nxt_s = seg_q_r;
          cnt_nxt_s     = 8'd1;
        end else if (cnt_r < STABLE_MAX) begin
          cnt_nxt_s    = cnt_r + 8'd1;
          commit_nxt_s = (cnt_r == STABLE_PRE);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // Commit data path: update the selected digit and the frame mask.
  always_comb begin
    dec_s       = decode_seg(cur_pat_r);
    value_nxt_s = value;
    valid_nxt_s = digit_valid;
    bad_nxt_s   = bad_pattern;
    seen_or_s   = seen_r | (4'b0001 << cur_idx_r);
    seen_nxt_s  = seen_r;
    frame_nxt_s = 1'b0;
    if (commit_nxt_s) begin
      value_nxt_s[{cur_idx_r, 2'b00} +: 4] = dec_s[5] ? dec_s[3:0] : 4'h0;
      valid_nxt_s[cur_idx_r]               = dec_s[5];
      bad_nxt_s[cur_idx_r]                 = ~(dec_s[5] | dec_s[4]);
      if (seen_or_s == 4'hF) begin
        frame_nxt_s = 1'b1;
        seen_nxt_s  = 4'h0;
      end else begin
        frame_nxt_s = 1'b0;
        seen_nxt_s  = seen_or_s;
      end
    end else begin
      frame_nxt_s = 1'b0;
    end
  end

  // Output registers: hold between commits, pulses last one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      value       <= 16'h0000;
      digit_valid <= 4'h0;
      bad_pattern <= 4'h0;
      commit      <= 1'b0;
      frame_done  <= 1'b0;
      seen_r      <= 4'h0;
    end else begin
      value       <= value_nxt_s;
      digit_valid <= valid_nxt_s;
      bad_pattern <= bad_nxt_s;
      commit      <= commit_nxt_s;
      frame_done  <= frame_nxt_s;
      seen_r      <= seen_nxt_s;
    end
  end

endmodule
